// File: rtl/pmem_responder_if.sv
// pmem_* line interface between the L1 cache (master) and
// the backing memory responder (slave).
interface pmem_responder_if;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;
    logic         busy;
    logic         err;

    modport master (
        output pmem_read,
        output pmem_write,
        output pmem_address,
        output pmem_wdata,
        input  pmem_resp,
        input  pmem_rdata,
        input  busy,
        input  err
    );

    modport slave (
        input  pmem_read,
        input  pmem_write,
        input  pmem_address,
        input  pmem_wdata,
        output pmem_resp,
        output pmem_rdata,
        output busy,
        output err
    );
endinterface

// File: rtl/pmem_responder.sv
// Fixed-latency cacheline backing store for the pmem_* interface.
// Optional protocol checker: define PMEM_RESPONDER_ERRCHK_EN.
module pmem_responder #(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    pmem_responder_if.slave   bus
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    op_wr_q, op_wr_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [127:0]            wdata_q, wdata_d;
    logic [127:0]            rdata_q, rdata_d;
    logic [127:0]            mem [DEPTH];
    logic                    req;
    logic                    unused_addr;

    assign req         = bus.pmem_read | bus.pmem_write;
    assign unused_addr = ^bus.pmem_address;

    // State and request-latch registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next state: accept, count down, abort on dropped request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    op_wr_d = bus.pmem_write;
                    idx_d   = bus.pmem_address[4 +: DEPTH_LOG2];
                    wdata_d = bus.pmem_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (state_q != RESP && state_d == RESP && !op_wr_d) begin
            rdata_d = mem[idx_d];
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        bus.pmem_resp  = (state_q == RESP) && req;
        bus.busy       = (state_q != IDLE);
        bus.pmem_rdata = rdata_q;
    end

    // Line storage: commit on the edge leaving a live RESP cycle.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == RESP && req && op_wr_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

`ifdef PMEM_RESPONDER_ERRCHK_EN
    logic        err_q, err_d;
    logic [15:0] addr_q, addr_d;

    // Sticky protocol-error detection.
    always_comb begin
        addr_d = addr_q;
        if (state_q == IDLE && req) begin
            addr_d = bus.pmem_address;
        end
        err_d = err_q
              | (bus.pmem_read & bus.pmem_write)
              | ((state_q != IDLE) && (bus.pmem_address != addr_q))
              | ((state_q != IDLE) && !req);
    end

    // Error flag and latched address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            err_q  <= err_d;
            addr_q <= addr_d;
            if (err_d && !err_q) begin
                $error("pmem_responder: protocol error");
            end
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: LATENCY 4, LATENCY 1
// and a DEPTH_LOG2=3 aliasing instance share one stimulus bus.
module tb_pmem_responder;

    logic         clk;
    logic         rst_n;
    logic         rd_r;
    logic         wr_r;
    logic [15:0]  addr_r;
    logic [127:0] wd_r;
    int           sel;
    int           n_chk;
    int           n_fail;

    logic         s_resp;
    logic         s_busy;
    logic         s_err;
    logic [127:0] s_rdata;

    localparam logic [127:0] LINE1 = {16'h0001, 16'h0002, 16'h0003,
        16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
    localparam logic [127:0] LINE_A  = {8{16'hAAAA}};
    localparam logic [127:0] LINE_5  = {8{16'h5555}};
    localparam logic [127:0] LINE_OLD = {8{16'h0BAD}};
    localparam logic [127:0] LINE_1S = {8{16'h1111}};
    localparam logic [127:0] LINE_V  = {4{32'hCAFE_F00D}};

    pmem_responder_if b0 ();
    pmem_responder_if b1 ();
    pmem_responder_if b2 ();

    assign b0.pmem_read    = rd_r;
    assign b0.pmem_write   = wr_r;
    assign b0.pmem_address = addr_r;
    assign b0.pmem_wdata   = wd_r;
    assign b1.pmem_read    = rd_r;
    assign b1.pmem_write   = wr_r;
    assign b1.pmem_address = addr_r;
    assign b1.pmem_wdata   = wd_r;
    assign b2.pmem_read    = rd_r;
    assign b2.pmem_write   = wr_r;
    assign b2.pmem_address = addr_r;
    assign b2.pmem_wdata   = wd_r;

    pmem_responder #(.LATENCY(4), .DEPTH_LOG2(12)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    pmem_responder #(.LATENCY(1), .DEPTH_LOG2(12)) u_lat1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    pmem_responder #(.LATENCY(4), .DEPTH_LOG2(3)) u_d3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (sel)
            1: begin
                s_resp  = b1.pmem_resp;
                s_busy  = b1.busy;
                s_err   = b1.err;
                s_rdata = b1.pmem_rdata;
            end
            2: begin
                s_resp  = b2.pmem_resp;
                s_busy  = b2.busy;
                s_err   = b2.err;
                s_rdata = b2.pmem_rdata;
            end
            default: begin
                s_resp  = b0.pmem_resp;
                s_busy  = b0.busy;
                s_err   = b0.err;
                s_rdata = b0.pmem_rdata;
            end
        endcase
    end

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered one step after a posedge with the selected DUT idle.
    // rc = cycle of first pmem_resp relative to acceptance, FF if none.
    task automatic xfer(input logic rd, input logic wr,
                        input logic [15:0] a, input logic [127:0] wd,
                        output logic [7:0] rc, output logic [127:0] rdo);
        rc  = 8'hFF;
        rdo = '0;
        rd_r   = rd;
        wr_r   = wr;
        addr_r = a;
        wd_r   = wd;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (s_resp && rc == 8'hFF) begin
                rc  = 8'(k);
                rdo = s_rdata;
            end
            step();
            if (rc != 8'hFF) break;
        end
        rd_r = 1'b0;
        wr_r = 1'b0;
    endtask

    logic [7:0]   rc;
    logic [127:0] rdo;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        sel    = 0;
        rst_n  = 1'b0;
        rd_r   = 1'b0;
        wr_r   = 1'b0;
        addr_r = '0;
        wd_r   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp",  128'(s_resp), 128'(0));
        check("rst_rdata", s_rdata, 128'(0));
        check("rst_busy",  128'(s_busy), 128'(0));
        check("rst_err",   128'(s_err), 128'(0));
        rst_n = 1'b1;
        step();

        xfer(1'b0, 1'b1, 16'h1230, LINE1, rc, rdo);
        check("wr_lat", 128'(rc), 128'(4));
        xfer(1'b1, 1'b0, 16'h1238, '0, rc, rdo);
        check("rd_lat", 128'(rc), 128'(4));
        check("rd_data", rdo, LINE1);

        xfer(1'b1, 1'b1, 16'h0040, LINE_A, rc, rdo);
        check("rw_lat", 128'(rc), 128'(4));
`ifdef PMEM_RESPONDER_ERRCHK_EN
        check("rw_err", 128'(s_err), 128'(1));
`else
        check("rw_err", 128'(s_err), 128'(0));
`endif
        xfer(1'b1, 1'b0, 16'h0040, '0, rc, rdo);
        check("rw_rdback", rdo, LINE_A);

        xfer(1'b0, 1'b1, 16'h0050, LINE_OLD, rc, rdo);
        wr_r   = 1'b1;
        addr_r = 16'h0050;
        wd_r   = LINE_5;
        step();
        step();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rstmid_resp", 128'(s_resp), 128'(0));
        end
        wr_r = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        @(negedge clk);
        check("rstmid_busy", 128'(s_busy), 128'(0));
        check("rstmid_rdata", s_rdata, 128'(0));
        step();
        xfer(1'b1, 1'b0, 16'h0050, '0, rc, rdo);
        check("rstmid_lat", 128'(rc), 128'(4));
        check("rstmid_old", rdo, LINE_OLD);

        xfer(1'b1, 1'b0, 16'h1230, '0, rc, rdo);
        check("pre_drop", rdo, LINE1);
        rd_r   = 1'b1;
        addr_r = 16'h0040;
        step();
        step();
        rd_r = 1'b0;
        @(negedge clk);
        check("drop_resp2", 128'(s_resp), 128'(0));
        step();
        @(negedge clk);
        check("drop_busy3", 128'(s_busy), 128'(0));
        check("drop_resp3", 128'(s_resp), 128'(0));
        check("drop_rdata", s_rdata, LINE1);
`ifdef PMEM_RESPONDER_ERRCHK_EN
        check("drop_err", 128'(s_err), 128'(1));
`endif
        step();

        sel    = 1;
        wr_r   = 1'b1;
        addr_r = 16'h0100;
        wd_r   = LINE_V;
        @(negedge clk);
        check("l1_wr_resp0", 128'(s_resp), 128'(0));
        check("l1_wr_busy0", 128'(s_busy), 128'(0));
        step();
        @(negedge clk);
        check("l1_wr_resp1", 128'(s_resp), 128'(1));
        check("l1_wr_busy1", 128'(s_busy), 128'(1));
        step();
        wr_r = 1'b0;
        rd_r = 1'b1;
        @(negedge clk);
        check("l1_rd_resp0", 128'(s_resp), 128'(0));
        check("l1_rd_busy0", 128'(s_busy), 128'(0));
        step();
        @(negedge clk);
        check("l1_rd_resp1", 128'(s_resp), 128'(1));
        check("l1_rd_busy1", 128'(s_busy), 128'(1));
        check("l1_rd_data", s_rdata, LINE_V);
        step();
        rd_r = 1'b0;
        @(negedge clk);
        check("l1_rd_busy2", 128'(s_busy), 128'(0));
        check("l1_rd_resp2", 128'(s_resp), 128'(0));
        repeat (3) step();

        sel = 2;
        xfer(1'b0, 1'b1, 16'h0010, LINE_1S, rc, rdo);
        check("d3_wr_lat", 128'(rc), 128'(4));
        xfer(1'b1, 1'b0, 16'h0090, '0, rc, rdo);
        check("d3_alias", rdo, LINE_1S);
        sel = 0;
        xfer(1'b1, 1'b0, 16'h0090, '0, rc, rdo);
        check("d12_noalias_lat", 128'(rc), 128'(4));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
